mdu_iter: RTL

// Parametrised multi-cycle multiply/divide unit for the EX stage; generalises the combinational mult/div path

---
 rtl/mdu_iter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit for the EX stage.
// One multiplier bit (shift-add) or one quotient bit (restoring divide) is
// processed per cycle over WIDTH cycles. Signed operations run on operand
// magnitudes and the signs are re-applied when the last iteration completes.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, op         request (accepted only when idle) and operation:
//                     00 mult, 01 multu, 10 div, 11 divu
//   srcA, srcB        multiplicand/dividend, multiplier/divisor (sampled with start)
//   cancel            abort; dominant over start; suppresses the result
//   busy              high while calculating and during the done cycle
//   done, we_hi/lo    one-cycle result strobe
//   hi_out, lo_out    mult: product high/low; div: remainder/quotient
//   div_by_zero       valid with done; divide with zero divisor
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             we_hi,
    output logic             we_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q, a_raw_q;
    logic               is_div_q, res_neg_q, rem_neg_q, div_zero_q;
    logic               busy_q, done_q, dz_out_q;
    logic [WIDTH-1:0]   hi_out_q, lo_out_q;

    logic               accept, finish;
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
        accept = (state_q == S_IDLE) && start && !cancel;
        finish = (state_q == S_CALC) && (cnt_q == LAST) && !cancel;
    end

    // ---------------- operand conditioning ----------------
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & srcA[WIDTH-1];
        b_neg     = signed_op & srcB[WIDTH-1];
        abs_a     = a_neg ? -srcA : srcA;
        abs_b     = b_neg ? -srcB : srcB;
    end

    // ---------------- one iteration ----------------
    // Multiply: {acc_hi, acc_lo} is the 2W-bit accumulator with the multiplier
    // in acc_lo, shifted right each step. Divide: acc_hi holds the partial
    // remainder, acc_lo shifts the dividend out and the quotient bits in.
    always_comb begin
        add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
        rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b_q};
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                acc_hi_d = rem_diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = rem_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_d = add_sum[WIDTH:1];
            acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up on the final iteration ----------------
    always_comb begin
        prod_raw = {acc_hi_d, acc_lo_d};
        prod_fix = res_neg_q ? -prod_raw : prod_raw;
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_hi = rem_neg_q ? -acc_hi_d : acc_hi_d;
                res_lo = res_neg_q ? -acc_lo_d : acc_lo_d;
            end
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_out_q   <= 1'b0;
            hi_out_q   <= '0;
            lo_out_q   <= '0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= finish;
            if (accept) begin
                cnt_q      <= '0;
                mag_a_q    <= abs_a;
                mag_b_q    <= abs_b;
                a_raw_q    <= srcA;
                is_div_q   <= op[1];
                res_neg_q  <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                div_zero_q <= op[1] & (srcB == '0);
                acc_hi_q   <= '0;
                acc_lo_q   <= op[1] ? abs_a : abs_b;
            end else if (state_q == S_CALC) begin
                cnt_q    <= cnt_q + 1'b1;
                acc_hi_q <= acc_hi_d;
                acc_lo_q <= acc_lo_d;
            end
            if (finish) begin
                hi_out_q <= res_hi;
                lo_out_q <= res_lo;
                dz_out_q <= is_div_q & div_zero_q;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign we_hi       = done_q;
    assign we_lo       = done_q;
    assign hi_out      = hi_out_q;
    assign lo_out      = lo_out_q;
    assign div_by_zero = dz_out_q;

endmodule
